// File: rtl/doorlock_keypad_ctrl.sv
// doorlock_keypad_ctrl
// Keypad front end for the door lock decoder. Shifts in a 4-bit code one bit
// per key pulse, then presents it on state/ps_num for a fixed hold window.
// Optional feature: define DOORLOCK_KEYPAD_LOCKOUT_EN to count wrong codes and
// lock the keypad out after MAX_FAIL consecutive failures.
module doorlock_keypad_ctrl #(
    parameter int         HOLD_CYCLES    = 16,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [3:0] PASSWORD       = 4'b1101,
    parameter int         MAX_FAIL       = 3,
    parameter int         LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic       key_bit,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic [1:0] state,
    output logic [3:0] ps_num,
    output logic [2:0] bit_cnt,
    output logic       locked
);

    // One shared timer serves ENTRY inactivity, CHECK hold and LOCKOUT; it is
    // sized for the longest of the windows it has to measure.
    localparam int HT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
    localparam int TMR_MAX = (LOCKOUT_CYCLES > HT_MAX) ? LOCKOUT_CYCLES : HT_MAX;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
`else
    localparam int TMR_MAX = HT_MAX;
`endif
    localparam int TMR_W = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
    localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ENTRY   = 2'b01,
        S_CHECK   = 2'b10,
        S_LOCKOUT = 2'b11
    } fsm_t;

    fsm_t             fsm_reg, fsm_next;
    logic [3:0]       ps_num_reg, ps_num_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [1:0]       state_reg, state_next;
    logic             locked_reg, locked_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next, tmr_inc;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
    logic [FAIL_W-1:0] fail_cnt_reg, fail_cnt_next;
`else
    // Lockout parameters have no function in this build; fold them into a
    // dead signal so they stay referenced.
    logic unused_cfg;
    assign unused_cfg = (^PASSWORD) ^ (MAX_FAIL > 0) ^ (LOCKOUT_CYCLES > 0);
`endif

    // Saturating increment so the timer can never wrap back to zero.
    assign tmr_inc = (tmr_reg == {TMR_W{1'b1}}) ? tmr_reg : tmr_reg + 1'b1;

    // Register all state and outputs; reset aborts any activity to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg      <= S_IDLE;
            ps_num_reg   <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            state_reg    <= 2'b00;
            locked_reg   <= 1'b0;
            tmr_reg      <= '0;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
            fail_cnt_reg <= '0;
`endif
        end else begin
            fsm_reg      <= fsm_next;
            ps_num_reg   <= ps_num_next;
            bit_cnt_reg  <= bit_cnt_next;
            state_reg    <= state_next;
            locked_reg   <= locked_next;
            tmr_reg      <= tmr_next;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
            fail_cnt_reg <= fail_cnt_next;
`endif
        end
    end

    // Next-state logic: key priority is clear > enter > valid.
    always_comb begin
        fsm_next     = fsm_reg;
        ps_num_next  = ps_num_reg;
        bit_cnt_next = bit_cnt_reg;
        tmr_next     = tmr_reg;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
        fail_cnt_next = fail_cnt_reg;
`endif
        case (fsm_reg)
            S_IDLE: begin
                if (!key_clear && !key_enter && key_valid) begin
                    fsm_next     = S_ENTRY;
                    ps_num_next  = {3'b000, key_bit};
                    bit_cnt_next = 3'd1;
                    tmr_next     = '0;
                end
            end
            S_ENTRY: begin
                if (key_clear || (key_enter && bit_cnt_reg != 3'd4)) begin
                    fsm_next     = S_IDLE;
                    ps_num_next  = 4'd0;
                    bit_cnt_next = 3'd0;
                    tmr_next     = '0;
                end else if (key_enter) begin
                    fsm_next = S_CHECK;
                    tmr_next = '0;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
                    if (ps_num_reg != PASSWORD) begin
                        if (fail_cnt_reg != FAIL_MAX)
                            fail_cnt_next = fail_cnt_reg + 1'b1;
                    end else begin
                        fail_cnt_next = '0;
                    end
`endif
                end else if (key_valid) begin
                    tmr_next = '0;
                    if (bit_cnt_reg != 3'd4) begin
                        ps_num_next  = {ps_num_reg[2:0], key_bit};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else if (tmr_reg == TIMEOUT_LAST) begin
                    fsm_next     = S_IDLE;
                    ps_num_next  = 4'd0;
                    bit_cnt_next = 3'd0;
                    tmr_next     = '0;
                end else begin
                    tmr_next = tmr_inc;
                end
            end
            S_CHECK: begin
                if (tmr_reg == HOLD_LAST) begin
                    fsm_next     = S_IDLE;
                    ps_num_next  = 4'd0;
                    bit_cnt_next = 3'd0;
                    tmr_next     = '0;
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
                    if (fail_cnt_reg == FAIL_MAX)
                        fsm_next = S_LOCKOUT;
`endif
                end else begin
                    tmr_next = tmr_inc;
                end
            end
`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
            S_LOCKOUT: begin
                if (tmr_reg == LOCK_LAST) begin
                    fsm_next      = S_IDLE;
                    fail_cnt_next = '0;
                    tmr_next      = '0;
                end else begin
                    tmr_next = tmr_inc;
                end
            end
`endif
            default: begin
                fsm_next     = S_IDLE;
                ps_num_next  = 4'd0;
                bit_cnt_next = 3'd0;
                tmr_next     = '0;
            end
        endcase
    end

    // Decoder-facing encodings: lockout looks like idle on the state bus.
    always_comb begin
        state_next  = (fsm_next == S_LOCKOUT) ? 2'b00 : 2'(fsm_next);
        locked_next = (fsm_next == S_LOCKOUT);
    end

    assign state   = state_reg;
    assign ps_num  = ps_num_reg;
    assign bit_cnt = bit_cnt_reg;
    assign locked  = locked_reg;

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// tb_doorlock_keypad_ctrl
// Directed bench for doorlock_keypad_ctrl; covers the lockout feature when
// DOORLOCK_KEYPAD_LOCKOUT_EN is defined.
module tb_doorlock_keypad_ctrl;

    localparam int HOLD = 16;
    localparam int TO   = 1000;
    localparam int LOCK = 5000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid, key_bit, key_enter, key_clear;
    logic [1:0] state;
    logic [3:0] ps_num;
    logic [2:0] bit_cnt;
    logic       locked;

    int n_cmp = 0;
    int n_err = 0;

    doorlock_keypad_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TO),
        .PASSWORD       (4'b1101),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .state     (state),
        .ps_num    (ps_num),
        .bit_cnt   (bit_cnt),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("  ok %s = %0d", tag, obs);
        end
    endtask

    // Drive one cycle of key inputs, return 1ns after the sampling edge.
    task automatic press(input logic v, input logic b, input logic e, input logic c);
        @(negedge clk);
        key_valid = v; key_bit = b; key_enter = e; key_clear = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0; key_bit = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_code(input logic [3:0] code);
        for (int i = 3; i >= 0; i--) press(1'b1, code[i], 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Count cycles spent at state=10, bounded.
    task automatic count_check(output int n);
        n = 0;
        while (state == 2'b10 && n < 200) begin
            n++;
            step(1);
        end
    endtask

    int n;
    int seen_check;

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0; key_bit = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
        step(3);
        check_val("reset state", int'(state), 0);
        check_val("reset ps_num", int'(ps_num), 0);
        check_val("reset bit_cnt", int'(bit_cnt), 0);
        check_val("reset locked", int'(locked), 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: full code 1101 and hold window
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t1 first bit state", int'(state), 1);
        check_val("t1 first bit ps_num", int'(ps_num), 1);
        check_val("t1 first bit bit_cnt", int'(bit_cnt), 1);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t1 ps_num", int'(ps_num), 13);
        check_val("t1 bit_cnt", int'(bit_cnt), 4);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t1 check state", int'(state), 2);
        check_val("t1 check ps_num", int'(ps_num), 13);
        count_check(n);
        check_val("t1 hold cycles", n, HOLD);
        check_val("t1 after state", int'(state), 0);
        check_val("t1 after ps_num", int'(ps_num), 0);
        check_val("t1 after bit_cnt", int'(bit_cnt), 0);

        // 2: short code rejected
        press(1'b1, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t2 state", int'(state), 0);
        check_val("t2 ps_num", int'(ps_num), 0);
        check_val("t2 bit_cnt", int'(bit_cnt), 0);
        seen_check = 0;
        for (int i = 0; i < 20; i++) begin
            if (state == 2'b10) seen_check = 1;
            step(1);
        end
        check_val("t2 no check", seen_check, 0);

        // 3: fifth bit ignored
        press(1'b1, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t3 ps_num", int'(ps_num), 11);
        check_val("t3 bit_cnt", int'(bit_cnt), 4);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t3 check state", int'(state), 2);
        check_val("t3 check ps_num", int'(ps_num), 11);
        count_check(n);
        check_val("t3 hold cycles", n, HOLD);

        // 4: inactivity timeout, then a key one cycle before it
        press(1'b1, 1'b1, 1'b0, 1'b0);
        step(TO - 1);
        check_val("t4 before timeout state", int'(state), 1);
        step(1);
        check_val("t4 timeout state", int'(state), 0);
        check_val("t4 timeout bit_cnt", int'(bit_cnt), 0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        step(TO - 2);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t4 late key state", int'(state), 1);
        check_val("t4 late key bit_cnt", int'(bit_cnt), 2);
        check_val("t4 late key ps_num", int'(ps_num), 2);
        step(TO - 1);
        check_val("t4 restarted state", int'(state), 1);
        step(1);
        check_val("t4 restarted timeout", int'(state), 0);

        // 5: clear wins over enter and valid; async reset in CHECK
        for (int i = 0; i < 4; i++) press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t5 full bit_cnt", int'(bit_cnt), 4);
        press(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("t5 clear state", int'(state), 0);
        check_val("t5 clear bit_cnt", int'(bit_cnt), 0);
        check_val("t5 clear ps_num", int'(ps_num), 0);
        enter_code(4'b1101);
        step(3);
        check_val("t5 in check", int'(state), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5 async state", int'(state), 0);
        check_val("t5 async ps_num", int'(ps_num), 0);
        check_val("t5 async bit_cnt", int'(bit_cnt), 0);
        check_val("t5 async locked", int'(locked), 0);
        @(negedge clk) rst_n = 1'b1;
        step(2);

`ifdef DOORLOCK_KEYPAD_LOCKOUT_EN
        // 6: three wrong codes lock the keypad out
        for (int k = 0; k < 3; k++) begin
            enter_code(4'b0000);
            count_check(n);
            check_val("t6 wrong hold", n, HOLD);
            check_val("t6 locked after wrong", int'(locked), (k == 2) ? 1 : 0);
        end
        check_val("t6 lockout state", int'(state), 0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t6 key ignored state", int'(state), 0);
        check_val("t6 key ignored bit_cnt", int'(bit_cnt), 0);
        check_val("t6 still locked", int'(locked), 1);
        n = 0;
        while (locked && n < 2 * LOCK) begin
            n++;
            step(1);
        end
        check_val("t6 lockout length", n + 1, LOCK);
        check_val("t6 unlocked state", int'(state), 0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t6 keys accepted again", int'(state), 1);
        press(1'b0, 1'b0, 1'b0, 1'b1);

        // wrong, wrong, right clears the count; two more wrongs do not lock
        enter_code(4'b0000); count_check(n);
        enter_code(4'b0001); count_check(n);
        enter_code(4'b1101); count_check(n);
        check_val("t6 right code no lock", int'(locked), 0);
        enter_code(4'b0000); count_check(n);
        enter_code(4'b0000); count_check(n);
        check_val("t6 count cleared", int'(locked), 0);
`else
        check_val("t6 locked tied low", int'(locked), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
